// File: rtl/mfb_meta_inserter_pkg.sv
// Shared helpers for mfb_meta_inserter: width functions, popcount and the metadata item type.
package mfb_meta_inserter_pkg;

    localparam int unsigned POPCNT_W = 64;
    localparam int unsigned META_W   = 2;

    typedef logic [META_W-1:0] meta_item_t;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

    function automatic int unsigned occ_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int unsigned sof_pos_width(input int unsigned region_size);
        return (region_size > 1) ? $clog2(region_size) : 1;
    endfunction

    function automatic int unsigned eof_pos_width(input int unsigned region_size,
                                                  input int unsigned block_size);
        return (region_size * block_size > 1) ? $clog2(region_size * block_size) : 1;
    endfunction

    function automatic int unsigned popcount(input logic [POPCNT_W-1:0] v);
        int unsigned c;
        c = 0;
        for (int i = 0; i < POPCNT_W; i++) begin
            c += {31'b0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/mfb_meta_inserter_fifo.sv
// Multi-write / multi-read register-array FIFO for metadata items.
// Valid write lanes are packed in lane order; read port k always shows the item at rd_ptr+k.
module mfb_meta_inserter_fifo
    import mfb_meta_inserter_pkg::*;
#(
    parameter int unsigned WR_ITEMS = 8,
    parameter int unsigned RD_ITEMS = 2,
    parameter int unsigned WIDTH    = 2,
    parameter int unsigned DEPTH    = 32,
    localparam int unsigned PTR_W   = ptr_width(DEPTH),
    localparam int unsigned OCC_W   = occ_width(DEPTH)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [WR_ITEMS*WIDTH-1:0] wr_data_i,
    input  logic [WR_ITEMS-1:0]       wr_vld_i,
    input  logic                      wr_en_i,
    input  logic [OCC_W-1:0]          rd_cnt_i,
    output logic [RD_ITEMS*WIDTH-1:0] rd_data_o,
    output logic [OCC_W-1:0]          occ_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [OCC_W-1:0] wr_cnt;

    always_comb begin
        mem_d  = mem_q;
        wr_cnt = '0;
        for (int i = 0; i < WR_ITEMS; i++) begin
            if (wr_en_i && wr_vld_i[i]) begin
                mem_d[wr_ptr_q + wr_cnt[PTR_W-1:0]] = wr_data_i[i*WIDTH +: WIDTH];
                wr_cnt = wr_cnt + OCC_W'(1);
            end
        end
        wr_ptr_d = wr_ptr_q + wr_cnt[PTR_W-1:0];
        rd_ptr_d = rd_ptr_q + rd_cnt_i[PTR_W-1:0];
        occ_d    = occ_q + wr_cnt - rd_cnt_i;
    end

    always_comb begin
        rd_data_o = '0;
        for (int k = 0; k < RD_ITEMS; k++) begin
            rd_data_o[k*WIDTH +: WIDTH] = mem_q[rd_ptr_q + PTR_W'(k)];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is readable.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    assign occ_o = occ_q;

endmodule

// File: rtl/mfb_meta_inserter.sv
// Attaches one buffered MVB metadata item to each MFB frame on its SOF (or EOF) region.
// Optional registered output stage: define MFB_META_INSERTER_OUT_REG_EN.
module mfb_meta_inserter
    import mfb_meta_inserter_pkg::*;
#(
    parameter int unsigned MVB_ITEMS       = 8,
    parameter int unsigned MFB_REGIONS     = 2,
    parameter int unsigned MFB_REGION_SIZE = 1,
    parameter int unsigned MFB_BLOCK_SIZE  = 8,
    parameter int unsigned MFB_ITEM_WIDTH  = 32,
    parameter int unsigned MFB_META_WIDTH  = 2,
    parameter int unsigned INSERT_MODE     = 0,
    parameter int unsigned FIFO_DEPTH      = 32,
    localparam int unsigned DATA_W    = MFB_REGIONS * MFB_REGION_SIZE * MFB_BLOCK_SIZE
                                        * MFB_ITEM_WIDTH,
    localparam int unsigned SOF_POS_W = sof_pos_width(MFB_REGION_SIZE),
    localparam int unsigned EOF_POS_W = eof_pos_width(MFB_REGION_SIZE, MFB_BLOCK_SIZE),
    localparam int unsigned OCC_W     = occ_width(FIFO_DEPTH)
) (
    input  logic                                CLK,
    input  logic                                RESET,

    input  logic [MVB_ITEMS*MFB_META_WIDTH-1:0] RX_MVB_DATA,
    input  logic [MVB_ITEMS-1:0]                RX_MVB_VLD,
    input  logic                                RX_MVB_SRC_RDY,
    output logic                                RX_MVB_DST_RDY,

    input  logic [DATA_W-1:0]                   RX_MFB_DATA,
    input  logic [MFB_REGIONS-1:0]              RX_MFB_SOF,
    input  logic [MFB_REGIONS-1:0]              RX_MFB_EOF,
    input  logic [MFB_REGIONS*SOF_POS_W-1:0]    RX_MFB_SOF_POS,
    input  logic [MFB_REGIONS*EOF_POS_W-1:0]    RX_MFB_EOF_POS,
    input  logic                                RX_MFB_SRC_RDY,
    output logic                                RX_MFB_DST_RDY,

    output logic [DATA_W-1:0]                   TX_MFB_DATA,
    output logic [MFB_REGIONS-1:0]              TX_MFB_SOF,
    output logic [MFB_REGIONS-1:0]              TX_MFB_EOF,
    output logic [MFB_REGIONS*SOF_POS_W-1:0]    TX_MFB_SOF_POS,
    output logic [MFB_REGIONS*EOF_POS_W-1:0]    TX_MFB_EOF_POS,
    output logic [MFB_REGIONS*MFB_META_WIDTH-1:0] TX_MFB_META,
    output logic                                TX_MFB_SRC_RDY,
    input  logic                                TX_MFB_DST_RDY
);

    logic [MFB_REGIONS-1:0]                ev;
    logic [OCC_W-1:0]                      ev_cnt;
    logic [OCC_W-1:0]                      occ;
    logic [OCC_W-1:0]                      rd_cnt;
    logic [MFB_REGIONS*MFB_META_WIDTH-1:0] rd_data;
    logic [MFB_REGIONS*MFB_META_WIDTH-1:0] meta;
    logic                                  occ_ok;
    logic                                  out_rdy;
    logic                                  xfer;

    assign ev     = (INSERT_MODE == 0) ? RX_MFB_SOF : RX_MFB_EOF;
    assign ev_cnt = OCC_W'(popcount(POPCNT_W'(ev)));
    assign occ_ok = (occ >= ev_cnt);
    assign rd_cnt = xfer ? ev_cnt : '0;

    assign RX_MVB_DST_RDY = (32'(occ) + MVB_ITEMS) <= FIFO_DEPTH;

    mfb_meta_inserter_fifo #(
        .WR_ITEMS (MVB_ITEMS),
        .RD_ITEMS (MFB_REGIONS),
        .WIDTH    (MFB_META_WIDTH),
        .DEPTH    (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (CLK),
        .rst_i     (RESET),
        .wr_data_i (RX_MVB_DATA),
        .wr_vld_i  (RX_MVB_VLD),
        .wr_en_i   (RX_MVB_SRC_RDY && RX_MVB_DST_RDY),
        .rd_cnt_i  (rd_cnt),
        .rd_data_o (rd_data),
        .occ_o     (occ)
    );

    // The k-th event region (ascending index) takes the k-th oldest buffered item.
    always_comb begin
        int unsigned k;
        meta = '0;
        k    = 0;
        for (int r = 0; r < MFB_REGIONS; r++) begin
            if (ev[r]) begin
                meta[r*MFB_META_WIDTH +: MFB_META_WIDTH] =
                    rd_data[k*MFB_META_WIDTH +: MFB_META_WIDTH];
                k++;
            end
        end
    end

`ifdef MFB_META_INSERTER_OUT_REG_EN
    localparam int unsigned STG_W = DATA_W + 2 * MFB_REGIONS
                                    + MFB_REGIONS * (SOF_POS_W + EOF_POS_W + MFB_META_WIDTH);

    logic             stg_vld_q, stg_vld_d;
    logic [STG_W-1:0] stg_q, stg_d;

    assign out_rdy = !stg_vld_q || TX_MFB_DST_RDY;
    assign xfer    = RX_MFB_SRC_RDY && occ_ok && out_rdy;

    always_comb begin
        stg_vld_d = stg_vld_q;
        stg_d     = stg_q;
        if (out_rdy) begin
            stg_vld_d = RX_MFB_SRC_RDY && occ_ok;
            if (xfer) begin
                stg_d = {RX_MFB_DATA, RX_MFB_SOF, RX_MFB_EOF, RX_MFB_SOF_POS, RX_MFB_EOF_POS,
                         meta};
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            stg_vld_q <= 1'b0;
            stg_q     <= '0;
        end else begin
            stg_vld_q <= stg_vld_d;
            stg_q     <= stg_d;
        end
    end

    assign {TX_MFB_DATA, TX_MFB_SOF, TX_MFB_EOF, TX_MFB_SOF_POS, TX_MFB_EOF_POS,
            TX_MFB_META} = stg_q;
    assign TX_MFB_SRC_RDY = stg_vld_q;
    assign RX_MFB_DST_RDY = out_rdy && occ_ok;
`else
    assign out_rdy = TX_MFB_DST_RDY;
    assign xfer    = RX_MFB_SRC_RDY && occ_ok && out_rdy;

    assign TX_MFB_DATA    = RX_MFB_DATA;
    assign TX_MFB_SOF     = RX_MFB_SOF;
    assign TX_MFB_EOF     = RX_MFB_EOF;
    assign TX_MFB_SOF_POS = RX_MFB_SOF_POS;
    assign TX_MFB_EOF_POS = RX_MFB_EOF_POS;
    assign TX_MFB_META    = meta;
    assign TX_MFB_SRC_RDY = RX_MFB_SRC_RDY && occ_ok;
    assign RX_MFB_DST_RDY = out_rdy && occ_ok;
`endif

endmodule

// File: tb/tb_mfb_meta_inserter.sv
// Bench for mfb_meta_inserter: SOF-mode and EOF-mode instances share stimulus and are
// compared each cycle against a queue-based model of the metadata buffer.
module tb_mfb_meta_inserter;
    import mfb_meta_inserter_pkg::*;

    localparam int MVB   = 8;
    localparam int REG   = 2;
    localparam int DW    = 512;
    localparam int MW    = 2;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [MVB*MW-1:0] mvb_data;
    logic [MVB-1:0]    mvb_vld;
    logic              mvb_src;
    logic [DW-1:0]     mfb_data;
    logic [REG-1:0]    sof, eof;
    logic [REG-1:0]    sof_pos;
    logic [REG*3-1:0]  eof_pos;
    logic              mfb_src;
    logic              tx_dst;

    logic [1:0]        mvb_rdy, mfb_rdy, tx_src;
    logic [DW-1:0]     tx_data    [2];
    logic [REG-1:0]    tx_sof     [2];
    logic [REG-1:0]    tx_eof     [2];
    logic [REG-1:0]    tx_sof_pos [2];
    logic [REG*3-1:0]  tx_eof_pos [2];
    logic [REG*MW-1:0] tx_meta    [2];

    for (genvar m = 0; m < 2; m++) begin : g_dut
        mfb_meta_inserter #(
            .MVB_ITEMS       (MVB),
            .MFB_REGIONS     (REG),
            .MFB_REGION_SIZE (1),
            .MFB_BLOCK_SIZE  (8),
            .MFB_ITEM_WIDTH  (32),
            .MFB_META_WIDTH  (MW),
            .INSERT_MODE     (m),
            .FIFO_DEPTH      (DEPTH)
        ) u_dut (
            .CLK            (clk),
            .RESET          (rst),
            .RX_MVB_DATA    (mvb_data),
            .RX_MVB_VLD     (mvb_vld),
            .RX_MVB_SRC_RDY (mvb_src),
            .RX_MVB_DST_RDY (mvb_rdy[m]),
            .RX_MFB_DATA    (mfb_data),
            .RX_MFB_SOF     (sof),
            .RX_MFB_EOF     (eof),
            .RX_MFB_SOF_POS (sof_pos),
            .RX_MFB_EOF_POS (eof_pos),
            .RX_MFB_SRC_RDY (mfb_src),
            .RX_MFB_DST_RDY (mfb_rdy[m]),
            .TX_MFB_DATA    (tx_data[m]),
            .TX_MFB_SOF     (tx_sof[m]),
            .TX_MFB_EOF     (tx_eof[m]),
            .TX_MFB_SOF_POS (tx_sof_pos[m]),
            .TX_MFB_EOF_POS (tx_eof_pos[m]),
            .TX_MFB_META    (tx_meta[m]),
            .TX_MFB_SRC_RDY (tx_src[m]),
            .TX_MFB_DST_RDY (tx_dst)
        );
    end

    int checks = 0;
    int passed = 0;

    // Reference model: one item list per instance, oldest at the front.
    meta_item_t q0[$];
    meta_item_t q1[$];
    logic              exp_mvb_rdy [2];
    logic              exp_tx_src  [2];
    logic              exp_mfb_rdy [2];
    logic              exp_ok      [2];
    int                exp_n       [2];
    logic [REG*MW-1:0] exp_meta    [2];

    function automatic int qsize(input int m);
        return (m == 0) ? q0.size() : q1.size();
    endfunction

    function automatic meta_item_t qget(input int m, input int k);
        return (m == 0) ? q0[k] : q1[k];
    endfunction

    task automatic qpush(input int m, input meta_item_t v);
        if (m == 0) q0.push_back(v);
        else q1.push_back(v);
    endtask

    task automatic qpop(input int m);
        if (m == 0) void'(q0.pop_front());
        else void'(q1.pop_front());
    endtask

    task automatic model_eval();
        for (int m = 0; m < 2; m++) begin
            logic [REG-1:0] ev;
            int k;
            ev             = (m == 0) ? sof : eof;
            exp_n[m]       = $countones(ev);
            exp_ok[m]      = qsize(m) >= exp_n[m];
            exp_mvb_rdy[m] = (DEPTH - qsize(m)) >= MVB;
            exp_tx_src[m]  = mfb_src && exp_ok[m];
            exp_mfb_rdy[m] = tx_dst && exp_ok[m];
            exp_meta[m]    = '0;
            k = 0;
            if (exp_ok[m]) begin
                for (int r = 0; r < REG; r++) begin
                    if (ev[r]) begin
                        exp_meta[m][r*MW +: MW] = qget(m, k);
                        k++;
                    end
                end
            end
        end
    endtask

    task automatic model_update();
        for (int m = 0; m < 2; m++) begin
            if (mfb_src && tx_dst && exp_ok[m]) begin
                for (int i = 0; i < exp_n[m]; i++) qpop(m);
            end
            if (mvb_src && exp_mvb_rdy[m]) begin
                for (int i = 0; i < MVB; i++) begin
                    if (mvb_vld[i]) qpush(m, mvb_data[i*MW +: MW]);
                end
            end
        end
    endtask

    task automatic tick();
        model_eval();
        if (!rst) model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom();
        return d;
    endfunction

    task automatic idle();
        mvb_src  = 1'b0;
        mvb_vld  = '0;
        mvb_data = '0;
        mfb_src  = 1'b0;
        sof      = '0;
        eof      = '0;
        sof_pos  = '0;
        eof_pos  = '0;
        mfb_data = '0;
        tx_dst   = 1'b1;
    endtask

    task automatic push_items(input logic [MVB-1:0] vld, input logic [MVB*MW-1:0] data);
        mvb_src  = 1'b1;
        mvb_vld  = vld;
        mvb_data = data;
    endtask

    task automatic frame(input logic [REG-1:0] s, input logic [REG-1:0] e);
        mfb_src  = 1'b1;
        sof      = s;
        eof      = e;
        mfb_data = rand_data();
        eof_pos  = REG*3'($urandom());
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        q0.delete();
        q1.delete();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (mvb_rdy !== 2'b11) $display("FAIL reset_mvb_rdy got %b want 11", mvb_rdy);
        else passed++;
        checks++;
        if (tx_src !== 2'b00) $display("FAIL reset_tx_src got %b want 00", tx_src);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (mvb_rdy !== 2'b11) $display("FAIL post_reset_mvb_rdy got %b want 11", mvb_rdy);
        else passed++;
        frame(2'b01, 2'b00);
        #1;
        model_eval();
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (tx_src[m] !== exp_tx_src[m])
                $display("FAIL reset_sof_tx_src m=%0d got %b want %b", m, tx_src[m],
                         exp_tx_src[m]);
            else passed++;
        end
        idle();
        tick();
    endtask

    task automatic test_single_frame();
        push_items(8'h01, 16'h0002);
        tick();
        idle();
        repeat (2) tick();
        frame(2'b01, 2'b01);
        #1;
        model_eval();
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (tx_src[m] !== 1'b1 || tx_meta[m] !== exp_meta[m])
                $display("FAIL single_meta m=%0d got src=%b meta=%h want src=1 meta=%h", m,
                         tx_src[m], tx_meta[m], exp_meta[m]);
            else passed++;
            checks++;
            if (tx_data[m] !== mfb_data || tx_sof[m] !== sof || tx_eof_pos[m] !== eof_pos)
                $display("FAIL single_fwd m=%0d got sof=%b eof_pos=%h want sof=%b eof_pos=%h",
                         m, tx_sof[m], tx_eof_pos[m], sof, eof_pos);
            else passed++;
        end
        tick();
        frame(2'b01, 2'b01);
        #1;
        model_eval();
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (tx_src[m] !== exp_tx_src[m])
                $display("FAIL single_drained m=%0d got %b want %b", m, tx_src[m],
                         exp_tx_src[m]);
            else passed++;
        end
        idle();
    endtask

    task automatic test_stall();
        meta_item_t a, b;
        a = meta_item_t'($urandom());
        b = ~a;
        push_items(8'h01, {14'b0, a});
        tick();
        idle();
        frame(2'b11, 2'b11);
        push_items(8'h01, {14'b0, b});
        #1;
        model_eval();
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (tx_src[m] !== exp_tx_src[m] || mfb_rdy[m] !== exp_mfb_rdy[m])
                $display("FAIL stall m=%0d got src=%b rdy=%b want src=%b rdy=%b", m,
                         tx_src[m], mfb_rdy[m], exp_tx_src[m], exp_mfb_rdy[m]);
            else passed++;
        end
        tick();
        mvb_src = 1'b0;
        mvb_vld = '0;
        #1;
        model_eval();
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (tx_src[m] !== 1'b1 || mfb_rdy[m] !== 1'b1 || tx_meta[m] !== {b, a})
                $display("FAIL stall_release m=%0d got src=%b meta=%h want src=1 meta=%h", m,
                         tx_src[m], tx_meta[m], {b, a});
            else passed++;
        end
        tick();
        idle();
    endtask

    task automatic test_eof_mode();
        logic [REG-1:0] sofs [4];
        logic [REG-1:0] eofs [4];
        sofs = '{2'b01, 2'b00, 2'b00, 2'b00};
        eofs = '{2'b00, 2'b00, 2'b00, 2'b10};
        push_items(8'h01, 16'h0001);
        tick();
        idle();
        for (int w = 0; w < 4; w++) begin
            frame(sofs[w], eofs[w]);
            #1;
            model_eval();
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (tx_src[m] !== exp_tx_src[m] || tx_meta[m] !== exp_meta[m])
                    $display("FAIL eof_mode w=%0d m=%0d got src=%b meta=%h want src=%b meta=%h",
                             w, m, tx_src[m], tx_meta[m], exp_tx_src[m], exp_meta[m]);
                else passed++;
            end
            tick();
        end
        idle();
    endtask

    task automatic test_compaction();
        logic [MVB*MW-1:0] d;
        logic [REG*MW-1:0] want [4];
        want = '{4'h0, 4'h2, 4'h1, 4'h3};
        for (int i = 0; i < MVB; i++) d[i*MW +: MW] = MW'(i);
        push_items(8'b1010_0101, d);
        tick();
        idle();
        for (int f = 0; f < 4; f++) begin
            frame(2'b01, 2'b01);
            #1;
            model_eval();
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (tx_src[m] !== 1'b1 || tx_meta[m] !== want[f])
                    $display("FAIL compaction f=%0d m=%0d got src=%b meta=%h want src=1 meta=%h",
                             f, m, tx_src[m], tx_meta[m], want[f]);
                else passed++;
            end
            tick();
        end
        idle();
    endtask

    task automatic test_fill();
        for (int w = 0; w < 2; w++) begin
            push_items('1, 16'($urandom()));
            #1;
            model_eval();
            checks++;
            if (mvb_rdy !== {exp_mvb_rdy[1], exp_mvb_rdy[0]} || mvb_rdy !== 2'b11)
                $display("FAIL fill_accept w=%0d got %b want 11", w, mvb_rdy);
            else passed++;
            tick();
        end
        idle();
        #1;
        checks++;
        if (mvb_rdy !== 2'b00) $display("FAIL fill_full got %b want 00", mvb_rdy);
        else passed++;
        frame(2'b01, 2'b01);
        tick();
        idle();
        for (int c = 0; c < 10; c++) begin
            if (qsize(0) >= 2) frame(2'b11, 2'b11);
            else if (qsize(0) == 1) frame(2'b01, 2'b01);
            #1;
            model_eval();
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (mvb_rdy[m] !== exp_mvb_rdy[m] || tx_src[m] !== exp_tx_src[m])
                    $display("FAIL fill_drain c=%0d m=%0d got rdy=%b src=%b want rdy=%b src=%b",
                             c, m, mvb_rdy[m], tx_src[m], exp_mvb_rdy[m], exp_tx_src[m]);
                else passed++;
            end
            tick();
            idle();
        end
    endtask

    task automatic test_reset_mid();
        push_items(8'h1f, 16'($urandom()));
        tick();
        idle();
        frame(2'b01, 2'b00);
        #1;
        model_eval();
        checks++;
        if (tx_src !== {exp_tx_src[1], exp_tx_src[0]})
            $display("FAIL mid_before got %b want %b", tx_src, {exp_tx_src[1], exp_tx_src[0]});
        else passed++;
        #1;
        rst = 1'b1;
        q0.delete();
        q1.delete();
        #1;
        model_eval();
        checks++;
        if (mvb_rdy !== 2'b11 || tx_src !== {exp_tx_src[1], exp_tx_src[0]} || tx_src[0] !== 1'b0)
            $display("FAIL mid_async got rdy=%b src=%b want rdy=11 src=%b", mvb_rdy, tx_src,
                     {exp_tx_src[1], exp_tx_src[0]});
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        frame(2'b01, 2'b01);
        #1;
        checks++;
        if (tx_src !== 2'b00) $display("FAIL mid_wait got %b want 00", tx_src);
        else passed++;
        tick();
        push_items(8'h01, 16'h0003);
        #1;
        checks++;
        if (tx_src !== 2'b00) $display("FAIL mid_no_bypass got %b want 00", tx_src);
        else passed++;
        tick();
        mvb_src = 1'b0;
        #1;
        model_eval();
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (tx_src[m] !== 1'b1 || tx_meta[m] !== exp_meta[m])
                $display("FAIL mid_new_item m=%0d got src=%b meta=%h want src=1 meta=%h", m,
                         tx_src[m], tx_meta[m], exp_meta[m]);
            else passed++;
        end
        tick();
        idle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            mvb_src  = ($urandom_range(0, 3) != 0);
            mvb_vld  = MVB'($urandom());
            mvb_data = 16'($urandom());
            mfb_src  = ($urandom_range(0, 3) != 0);
            sof      = REG'($urandom());
            eof      = REG'($urandom());
            sof_pos  = REG'($urandom());
            eof_pos  = (REG*3)'($urandom());
            mfb_data = rand_data();
            tx_dst   = ($urandom_range(0, 4) != 0);
            #1;
            model_eval();
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (mvb_rdy[m] !== exp_mvb_rdy[m] || tx_src[m] !== exp_tx_src[m] ||
                    mfb_rdy[m] !== exp_mfb_rdy[m])
                    $display("FAIL rand_hs c=%0d m=%0d got %b%b%b want %b%b%b", c, m,
                             mvb_rdy[m], tx_src[m], mfb_rdy[m], exp_mvb_rdy[m],
                             exp_tx_src[m], exp_mfb_rdy[m]);
                else passed++;
                if (exp_tx_src[m]) begin
                    checks++;
                    if (tx_meta[m] !== exp_meta[m] || tx_eof[m] !== eof ||
                        tx_sof_pos[m] !== sof_pos || tx_data[m] !== mfb_data)
                        $display("FAIL rand_word c=%0d m=%0d got meta=%h want meta=%h", c, m,
                                 tx_meta[m], exp_meta[m]);
                    else passed++;
                end
            end
            tick();
        end
        idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_frame();
        test_stall();
        test_eof_mode();
        test_compaction();
        test_fill();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/mfb_meta_inserter.md
Name: mfb_meta_inserter

Overview:
- Opposite direction of the MFB metadata extractor.
- Takes one MVB metadata item per frame and attaches it to the matching MFB frame as per-region TX_MFB_META, aligned to the frame's SOF region or EOF region.
- Buffers MVB items in a small multi-port FIFO.
- Stalls the MFB stream when a word contains more frame starts (or ends) than there are buffered items.

Parameters:
- MVB_ITEMS, 8, MVB items per word.
- MFB_REGIONS, 2, MFB regions per word.
- MFB_REGION_SIZE, 1, blocks per region.
- MFB_BLOCK_SIZE, 8, items per block.
- MFB_ITEM_WIDTH, 32, bits per item.
- MFB_META_WIDTH, 2, metadata bits per region (also the MVB item width).
- INSERT_MODE, 0: 0 = metadata on SOF region; 1 = metadata on EOF region.
- FIFO_DEPTH, 32, metadata FIFO items; power of two, >= 2*MVB_ITEMS.

Ports:
- CLK  in  1  clock.
- RESET  in  1  asynchronous, active-high reset.
- RX_MVB_DATA  in  MVB_ITEMS*MFB_META_WIDTH  metadata items, lane 0 oldest.
- RX_MVB_VLD  in  MVB_ITEMS  per-item valid.
- RX_MVB_SRC_RDY  in  1  word valid.
- RX_MVB_DST_RDY  out  1  word accepted when high with SRC_RDY.
- RX_MFB_DATA  in  REGIONS*REGION_SIZE*BLOCK_SIZE*ITEM_WIDTH  frame data.
- RX_MFB_SOF  in  REGIONS  start of frame per region.
- RX_MFB_EOF  in  REGIONS  end of frame per region.
- RX_MFB_SOF_POS  in  REGIONS*max(1,log2(REGION_SIZE))  SOF block position.
- RX_MFB_EOF_POS  in  REGIONS*max(1,log2(REGION_SIZE*BLOCK_SIZE))  EOF item position.
- RX_MFB_SRC_RDY  in  1  word valid.
- RX_MFB_DST_RDY  out  1  word accepted.
- TX_MFB_DATA, TX_MFB_SOF, TX_MFB_EOF, TX_MFB_SOF_POS, TX_MFB_EOF_POS  out  same widths as RX  forwarded frame data.
- TX_MFB_META  out  REGIONS*MFB_META_WIDTH  inserted metadata.
- TX_MFB_SRC_RDY  out  1  word valid.
- TX_MFB_DST_RDY  in  1  downstream ready.

Behaviour:
- FIFO write:
  - RX_MVB_DST_RDY = (free >= MVB_ITEMS), combinational from registered occupancy.
  - On accept, valid items are written compacted in lane order; invalid lanes are skipped.
  - A word with zero valid items is accepted and writes nothing.
- Event count per word: N = popcount(RX_MFB_SOF) when INSERT_MODE=0, popcount(RX_MFB_EOF) when INSERT_MODE=1.
- MFB transfer condition: RX_MFB_SRC_RDY and occupancy >= N and output side ready.
  - On transfer, N items are read.
  - The k-th event region (ascending region index) gets item rd_ptr+k on its TX_MFB_META slice.
  - Non-event regions output zeros.
- A word with N=0 never waits on the FIFO.
- No bypass: items written in cycle t are readable from t+1. Simultaneous read and write update occupancy as occ + wr_cnt - rd_cnt.
- Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. Occupancy is log2(FIFO_DEPTH)+1 bits. Overflow and underflow are structurally impossible.
- RX_MFB_DST_RDY = TX_MFB_DST_RDY and (occupancy >= N). Ready depends on the current word's SOF/EOF; this is a documented exception, MFB sources do not depend on DST_RDY.
- TX_MFB_SRC_RDY = RX_MFB_SRC_RDY and (occupancy >= N).
- Latency without the output register: 0 cycles MFB→TX. MVB→usable: 1 cycle.
- Reset (asynchronous): pointers and occupancy go to 0.
  - RX_MVB_DST_RDY reads 1 immediately after reset deasserts.
  - TX_MFB_SRC_RDY is 0 while RX_MFB_SRC_RDY=0 or N > 0.
- Reset mid-frame discards buffered items; no recovery of partially sent frames.

Optional Feature:
- Macro MFB_META_INSERTER_OUT_REG_EN.
- Defined:
  - All TX_MFB_* outputs come from a registered stage with a 1-deep skid; latency is 1 cycle.
  - The registered TX_MFB_SRC_RDY resets to 0. Registered TX_MFB_META and data reset to 0.
  - RX_MFB_DST_RDY = (stage empty or TX_MFB_DST_RDY) and occupancy >= N.
- Undefined: combinational path as described above.

Decomposition:
- Package mfb_meta_inserter_pkg holds:
  - popcount function;
  - localparams for pointer and occupancy widths;
  - SOF_POS/EOF_POS width helpers;
  - meta item typedef (logic [MFB_META_WIDTH-1:0]).
- One sub-module mfb_meta_inserter_fifo:
  - MVB_ITEMS-write, MFB_REGIONS-read register-array FIFO;
  - ports: write vector + valid, read count + read vector, occupancy.

Test Plan:
- Single frame, SOF and EOF in region 0, INSERT_MODE=0, MVB item 2'b10 sent 3 cycles earlier → TX word has SOF[0]=1, META region0 = 2'b10, region1 = 2'b00; occupancy returns to 0.
- Two SOFs in one word, only 1 item buffered → TX_MFB_SRC_RDY=0 and RX_MFB_DST_RDY=0. Second item arrives at cycle t → word transfers at t+1 with META = {item1, item0}.
- INSERT_MODE=1, 4-word frame with SOF word0 and EOF word3 region1, item 2'b01 → META only on word3 region1 = 2'b01; words 0..2 META = 0.
- MVB word with VLD=8'b10100101 carrying items 0..7 → FIFO holds items 0,2,5,7 in that order; next four frames receive exactly those.
- FIFO_DEPTH=16, MVB_ITEMS=8, no MFB traffic → two MVB words accepted, then RX_MVB_DST_RDY=0. One frame consumes an item → DST_RDY stays 0 until free >= 8.
- Assert RESET mid-frame with 5 items buffered → outputs reset asynchronously, occupancy 0. The next frame after reset waits for a new MVB item.
